memory_bist: RTL and testbench

- March-style built-in self-test controller that sits directly upstream of the Memory block and is its sole bus master during test.
- Drives the Memory's addr, bidirectional data, wr and rd, and compares read-back data against expected values.
- Reports pass/fail plus the first failing address and data.
- Used at bring-up and in regression to qualify Memory instances of any ADDR_WIDTH/DATA_WIDTH.

---
 rtl/memory_bist.sv | 132 +++++++++++++
 tb/tb_memory_bist.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/memory_bist.sv
// March BIST controller: runs M0..M3 over the whole memory, owns the memory bus,
// and records the first read mismatch (address, expected, actual).
module memory_bist #(
    parameter int                    ADDR_WIDTH = 5,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] PATTERN    = DATA_WIDTH'(8'h55)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_expected,
    output logic [DATA_WIDTH-1:0] fail_actual,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    inout  wire  [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_wr,
    output logic                  mem_rd
);

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_RD_ADDR, S_RD_SAMPLE, S_FINISH
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

    state_t                state_q, state_d;
    logic [1:0]            elem_q, elem_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  pass_q, pass_d;
    logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_WIDTH-1:0] fail_exp_q, fail_exp_d;
    logic [DATA_WIDTH-1:0] fail_act_q, fail_act_d;

    logic [DATA_WIDTH-1:0] exp_data, wr_data;
    logic                  last_addr, advance;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            elem_q      <= '0;
            addr_q      <= '0;
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_exp_q  <= '0;
            fail_act_q  <= '0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            addr_q      <= addr_d;
            pass_q      <= pass_d;
            fail_addr_q <= fail_addr_d;
            fail_exp_q  <= fail_exp_d;
            fail_act_q  <= fail_act_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        addr_d      = addr_q;
        pass_d      = pass_q;
        fail_addr_d = fail_addr_q;
        fail_exp_d  = fail_exp_q;
        fail_act_d  = fail_act_q;
        advance     = 1'b0;

        exp_data  = (elem_q == 2'd2) ? ~PATTERN : PATTERN;
        wr_data   = (elem_q == 2'd1) ? ~PATTERN : PATTERN;
        // Elements 2 and 3 walk downwards.
        last_addr = elem_q[1] ? (addr_q == '0) : (addr_q == ADDR_MAX);

        case (state_q)
            S_IDLE, S_FINISH: begin
                state_d = S_IDLE;
                if (start) begin
                    state_d     = S_WRITE;
                    elem_d      = 2'd0;
                    addr_d      = '0;
                    pass_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_exp_d  = '0;
                    fail_act_d  = '0;
                end
            end
            S_WRITE:   advance = 1'b1;
            S_RD_ADDR: state_d = S_RD_SAMPLE;
            S_RD_SAMPLE: begin
                // Case inequality so a floating or unknown bus bit is a failure.
                if (mem_data !== exp_data) begin
                    state_d     = S_FINISH;
                    fail_addr_d = addr_q;
                    fail_exp_d  = exp_data;
                    fail_act_d  = mem_data;
                end else if (elem_q == 2'd1 || elem_q == 2'd2) begin
                    state_d = S_WRITE;
                end else begin
                    advance = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // M0->M1 wraps to 0, M2->M3 wraps to max, M1->M2 keeps the top address.
        if (advance) begin
            if (last_addr && elem_q == 2'd3) begin
                state_d = S_FINISH;
                pass_d  = 1'b1;
            end else begin
                state_d = S_RD_ADDR;
                if (last_addr) elem_d = elem_q + 2'd1;
                else if (elem_q == 2'd0) state_d = S_WRITE;
                if (!(last_addr && elem_q == 2'd1))
                    addr_d = elem_q[1] ? addr_q - 1'b1 : addr_q + 1'b1;
            end
        end
    end

    assign busy          = (state_q == S_WRITE) || (state_q == S_RD_ADDR) || (state_q == S_RD_SAMPLE);
    assign done          = (state_q == S_FINISH);
    assign pass          = pass_q;
    assign fail_addr     = fail_addr_q;
    assign fail_expected = fail_exp_q;
    assign fail_actual   = fail_act_q;
    assign mem_addr      = addr_q;
    assign mem_wr        = (state_q == S_WRITE);
    assign mem_rd        = (state_q == S_RD_ADDR) || (state_q == S_RD_SAMPLE);
    assign mem_data      = mem_wr ? wr_data : 'z;

endmodule

// File: tb/tb_memory_bist.sv
// Bench for memory_bist: behavioural memories with injectable faults, a table of
// fault scenarios, and directed sequences for reset-abort and PATTERN=0.
module tb_memory_bist;

    logic       clk = 1'b0;
    logic       rst;
    logic       start1, start2;
    logic       busy1, done1, pass1, mem_wr1, mem_rd1;
    logic [4:0] fail_addr1, mem_addr1;
    logic [7:0] fail_exp1, fail_act1;
    wire  [7:0] mem_data1;
    logic       busy2, done2, pass2, mem_wr2, mem_rd2;
    logic [4:0] fail_addr2, mem_addr2;
    logic [7:0] fail_exp2, fail_act2;
    wire  [7:0] mem_data2;

    int n_cmp = 0;
    int n_fail = 0;
    int viol = 0;
    int fault_mode = 0;   // 0 none, 1 addr5 bit3 stuck-at-1, 2 addr31 aliases addr0

    logic [7:0] mem1 [32];
    logic [7:0] mem2 [32];
    logic [4:0] ea1;
    logic [7:0] rd1, drv1, drv2;

    always #5 clk = ~clk;

    memory_bist #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .PATTERN(8'h55)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1), .pass(pass1),
        .fail_addr(fail_addr1), .fail_expected(fail_exp1), .fail_actual(fail_act1),
        .mem_addr(mem_addr1), .mem_data(mem_data1), .mem_wr(mem_wr1), .mem_rd(mem_rd1));

    memory_bist #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .PATTERN(8'h00)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2), .pass(pass2),
        .fail_addr(fail_addr2), .fail_expected(fail_exp2), .fail_actual(fail_act2),
        .mem_addr(mem_addr2), .mem_data(mem_data2), .mem_wr(mem_wr2), .mem_rd(mem_rd2));

    // Memory models: combinational read; when neither reading nor being written the
    // bench parks a known value on the bus, so any stray DUT drive shows up.
    assign ea1       = (fault_mode == 2 && mem_addr1 == 5'd31) ? 5'd0 : mem_addr1;
    assign rd1       = mem1[ea1] | ((fault_mode == 1 && mem_addr1 == 5'd5) ? 8'h08 : 8'h00);
    assign drv1      = mem_rd1 ? rd1 : 8'h00;
    assign drv2      = mem_rd2 ? mem2[mem_addr2] : 8'hFF;
    assign mem_data1 = mem_wr1 ? 8'bz : drv1;
    assign mem_data2 = mem_wr2 ? 8'bz : drv2;

    always @(posedge clk) begin
        if (mem_wr1) mem1[ea1] <= mem_data1;
        if (mem_wr2) mem2[mem_addr2] <= mem_data2;
    end

    always @(negedge clk) begin
        if (mem_wr1 && mem_rd1) viol++;
        if (mem_wr2 && mem_rd2) viol++;
        if (!mem_wr1 && mem_data1 !== drv1) viol++;
        if (!mem_wr2 && mem_data2 !== drv2) viol++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Start a run on dut1, count busy/write/done cycles until 3 cycles past done.
    task automatic run1(input bit repulse, output int bcnt, output int wcnt,
                        output int dcnt, output bit seen);
        int done_c = 0;
        bcnt = 0; wcnt = 0; dcnt = 0; seen = 1'b0;
        @(negedge clk);
        start1 = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (busy1) bcnt++;
            if (mem_wr1) wcnt++;
            if (done1) begin
                dcnt++;
                if (!seen) done_c = c;
                seen = 1'b1;
            end
            start1 = repulse && (c == 10 || c == 200);
            if (seen && c >= done_c + 3) break;
        end
        start1 = 1'b0;
    endtask

    typedef struct {
        int         mode;
        bit         repulse;
        bit         pass;
        logic [4:0] faddr;
        logic [7:0] fexp;
        logic [7:0] fact;
        int         busy;
        int         writes;
    } vec_t;

    vec_t tbl [4];

    initial begin
        int  bc, wc, dc, bad, k, ph;
        bit  seen;
        tbl[0] = '{mode: 0, repulse: 0, pass: 1, faddr: 5'd0,  fexp: 8'h00, fact: 8'h00, busy: 288, writes: 96};
        tbl[1] = '{mode: 1, repulse: 0, pass: 0, faddr: 5'd5,  fexp: 8'h55, fact: 8'h5D, busy: 49,  writes: 37};
        tbl[2] = '{mode: 2, repulse: 0, pass: 0, faddr: 5'd31, fexp: 8'h55, fact: 8'hAA, busy: 127, writes: 63};
        tbl[3] = '{mode: 0, repulse: 1, pass: 1, faddr: 5'd0,  fexp: 8'h00, fact: 8'h00, busy: 288, writes: 96};
        for (int i = 0; i < 32; i++) begin mem1[i] = 8'h00; mem2[i] = 8'h00; end

        rst = 1'b1; start1 = 1'b0; start2 = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_pass", pass1, 0);
        chk("rst_wr_rd", {mem_wr1, mem_rd1}, 0);
        chk("rst_addr", mem_addr1, 0);
        chk("rst_fail", {fail_addr1, fail_exp1, fail_act1}, 0);
        chk("rst_bus", mem_data1, 8'h00);
        rst = 1'b0;

        foreach (tbl[t]) begin
            fault_mode = tbl[t].mode;
            run1(tbl[t].repulse, bc, wc, dc, seen);
            chk($sformatf("v%0d_done_seen", t), seen, 1);
            chk($sformatf("v%0d_done_cnt", t), dc, 1);
            chk($sformatf("v%0d_busy_cycles", t), bc, tbl[t].busy);
            chk($sformatf("v%0d_writes", t), wc, tbl[t].writes);
            chk($sformatf("v%0d_pass", t), pass1, tbl[t].pass);
            chk($sformatf("v%0d_fail_addr", t), fail_addr1, tbl[t].faddr);
            chk($sformatf("v%0d_fail_exp", t), fail_exp1, tbl[t].fexp);
            chk($sformatf("v%0d_fail_act", t), fail_act1, tbl[t].fact);
            if (tbl[t].mode == 0) begin
                bad = 0;
                for (int i = 0; i < 32; i++) if (mem1[i] !== 8'h55) bad++;
                chk($sformatf("v%0d_mem_final", t), bad, 0);
            end
        end
        fault_mode = 0;

        // Reset in the middle of a run: immediate quiet bus, no done.
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (99) @(negedge clk);
        chk("abort_busy_before", busy1, 1);
        #1 rst = 1'b1;
        #1;
        chk("abort_busy", busy1, 0);
        chk("abort_wr_rd", {mem_wr1, mem_rd1}, 0);
        chk("abort_addr", mem_addr1, 0);
        chk("abort_pass_fail", {pass1, fail_addr1, fail_exp1, fail_act1}, 0);
        chk("abort_bus", mem_data1, 8'h00);
        dc = 0;
        repeat (3) begin @(negedge clk); if (done1) dc++; end
        rst = 1'b0;
        repeat (4) begin @(negedge clk); if (done1 || busy1) dc++; end
        chk("abort_no_done", dc, 0);
        run1(1'b0, bc, wc, dc, seen);
        chk("rerun_busy", bc, 288);
        chk("rerun_done", dc, 1);
        chk("rerun_pass", pass1, 1);

        // PATTERN=0 instance: in M2 (busy cycles 129..224) reads see FF, writes drive 00.
        bad = 0; bc = 0; dc = 0;
        @(negedge clk);
        start2 = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            start2 = 1'b0;
            k = c + 1;
            if (busy2) bc++;
            if (done2) dc++;
            if (k >= 129 && k <= 224) begin
                ph = (k - 129) % 3;
                if (mem_addr2 !== 5'(31 - (k - 129) / 3)) bad++;
                if (ph == 1 && !(mem_rd2 && mem_data2 === 8'hFF)) bad++;
                if (ph == 2 && !(mem_wr2 && mem_data2 === 8'h00)) bad++;
            end
        end
        chk("p0_m2_bus", bad, 0);
        chk("p0_busy", bc, 288);
        chk("p0_done", dc, 1);
        chk("p0_pass", pass2, 1);

        chk("bus_protocol", viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
